sys_arr_edge_feeder: RTL and testbench

- Transmit side of the PE operand handshake: buffers one FP32 operand vector and streams it into a systolic-array edge PE's row or column input (valid/ready/dat).
- One instance per array row or column, at the west or north edge.
- A per-instance SKEW delay produces the diagonal wavefront.
- A loaded vector can be replayed without reloading, for stationary-operand reuse.

---
 rtl/dsp_sys_arr_pkg.sv | 13 +
 rtl/sys_arr_edge_feeder_if.sv | 31 +++
 rtl/sys_arr_edge_feeder_buf.sv | 24 ++
 rtl/sys_arr_edge_feeder.sv | 116 +++++++++++
 tb/tb_sys_arr_edge_feeder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic-array datapath blocks.
package dsp_sys_arr_pkg;

  typedef logic [31:0] single_float;

  typedef enum logic [1:0] {
    IDLE,
    SKEW,
    STREAM,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/sys_arr_edge_feeder_if.sv
// Load-side and PE-side signals of one edge feeder; the master modport is the feeder itself.
interface sys_arr_edge_feeder_if
  import dsp_sys_arr_pkg::*;
#(
  parameter int LEN_W = 5
);

  logic             wr_en;
  single_float      wr_dat;
  logic             wr_ready;
  logic             clr;
  logic             start;
  logic [LEN_W-1:0] fill_cnt;
  single_float      out_dat;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             err_empty;

  modport master (
    input  wr_en, wr_dat, clr, start, out_ready,
    output wr_ready, fill_cnt, out_dat, out_valid, busy, done, err_empty
  );

  modport slave (
    output wr_en, wr_dat, clr, start, out_ready,
    input  wr_ready, fill_cnt, out_dat, out_valid, busy, done, err_empty
  );

endinterface

// File: rtl/sys_arr_edge_feeder_buf.sv
// Operand register file: synchronous write, asynchronous read, storage is not reset.
module feeder_buf
  import dsp_sys_arr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  single_float   wdat,
  input  logic [AW-1:0] raddr,
  output single_float   rdat
);

  single_float mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/sys_arr_edge_feeder.sv
// Edge feeder: buffers one FP32 operand vector and streams it, after a fixed skew, into a
// systolic-array edge PE; the vector stays loaded so it can be replayed.
module sys_arr_edge_feeder #(
  parameter int DEPTH = 16,
  parameter int SKEW  = 0,
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  sys_arr_edge_feeder_if.master bus
);

  import dsp_sys_arr_pkg::*;

  localparam int AW = $clog2(DEPTH);

  feeder_state_t    state, state_n;
  logic [LEN_W-1:0] wr_ptr, wr_ptr_n;
  logic [LEN_W-1:0] rd_ptr, rd_ptr_n;
  logic [LEN_W-1:0] len_n;
  logic [7:0]       skew_cnt, skew_cnt_n;
  logic             err_empty, err_empty_n;
  logic             wr_ready, wr_ok, out_valid;
  single_float      rd_dat;

  assign wr_ready  = ((state == IDLE) || (state == DONE)) && (wr_ptr < LEN_W'(DEPTH));
  assign wr_ok     = bus.wr_en && wr_ready && !bus.clr;
  assign out_valid = (state == STREAM);

  feeder_buf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr[AW-1:0]),
    .wdat (bus.wr_dat),
    .raddr(rd_ptr[AW-1:0]),
    .rdat (rd_dat)
  );

  // The parameter SKEW hides the state of the same name, so that state is package-qualified.
  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    skew_cnt_n  = skew_cnt;
    err_empty_n = 1'b0;
    len_n       = wr_ptr + LEN_W'(wr_ok);
    if (bus.clr) begin
      state_n    = IDLE;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      skew_cnt_n = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (wr_ok) begin
            wr_ptr_n = wr_ptr + LEN_W'(1);
            state_n  = IDLE;
          end
          if (bus.start) begin
            if (len_n == '0) begin
              err_empty_n = 1'b1;
              state_n     = IDLE;
            end else begin
              rd_ptr_n = '0;
              if (SKEW > 0) begin
                state_n    = dsp_sys_arr_pkg::SKEW;
                skew_cnt_n = 8'(SKEW - 1);
              end else begin
                state_n = STREAM;
              end
            end
          end
        end
        dsp_sys_arr_pkg::SKEW: begin
          if (skew_cnt == 8'd0) state_n = STREAM;
          else skew_cnt_n = skew_cnt - 8'd1;
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (rd_ptr == wr_ptr - LEN_W'(1)) state_n = DONE;
            else rd_ptr_n = rd_ptr + LEN_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      skew_cnt  <= '0;
      err_empty <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      skew_cnt  <= skew_cnt_n;
      err_empty <= err_empty_n;
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.fill_cnt  = wr_ptr;
  assign bus.out_valid = out_valid;
  assign bus.out_dat   = out_valid ? rd_dat : '0;
  assign bus.busy      = (state == dsp_sys_arr_pkg::SKEW) || (state == STREAM);
  assign bus.done      = (state == DONE);
  assign bus.err_empty = err_empty;

endmodule

// File: tb/tb_sys_arr_edge_feeder.sv
// Bench for sys_arr_edge_feeder: a SKEW=0 instance driven by a cycle table and corner-case
// sequences with a streaming scoreboard, plus a SKEW=2 instance for wavefront timing.
module tb_sys_arr_edge_feeder;

  localparam int DEPTH = 16;
  localparam logic [31:0] Z  = 32'h0000_0000;
  localparam logic [31:0] W0 = 32'h4040_0000;
  localparam logic [31:0] W1 = 32'h3FC0_0000;
  localparam logic [31:0] W2 = 32'hC000_0000;
  localparam logic [31:0] W3 = 32'h3F80_0000;

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        st;
    logic        cl;
    logic        rdy;
    logic        e_wrr;
    logic [4:0]  e_fill;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp    = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;

  logic [31:0] model_vec[$];
  logic [31:0] exp_q[$];
  logic        model_idle = 1'b1;

  sys_arr_edge_feeder_if #(.LEN_W(5)) bus0 ();
  sys_arr_edge_feeder_if #(.LEN_W(5)) bus2 ();

  sys_arr_edge_feeder #(.DEPTH(DEPTH), .SKEW(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sys_arr_edge_feeder #(.DEPTH(DEPTH), .SKEW(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t row(input int we, input logic [31:0] wd, input int st, input int cl,
                               input int rdy, input int wrr, input int fill, input int vld,
                               input logic [31:0] dat, input int busy, input int done,
                               input int err);
    vec_t r;
    r.we = (we != 0);   r.wd = wd;        r.st = (st != 0);     r.cl = (cl != 0);
    r.rdy = (rdy != 0); r.e_wrr = (wrr != 0); r.e_fill = 5'(fill); r.e_vld = (vld != 0);
    r.e_dat = dat;      r.e_busy = (busy != 0); r.e_done = (done != 0); r.e_err = (err != 0);
    return r;
  endfunction

  // Scoreboard: every handshake on the SKEW=0 instance must deliver the next expected word,
  // and out_dat must read zero whenever out_valid is low.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.out_valid && bus0.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_xfer: got %h, expected no transfer", bus0.out_dat);
        end else begin
          checkOutput("stream_dat", bus0.out_dat, exp_q.pop_front());
          xfer_cnt++;
          if (exp_q.size() == 0) model_idle = 1'b1;
        end
      end else if (!bus0.out_valid) begin
        checkOutput("dat_zero_when_idle", bus0.out_dat, Z);
      end
    end
  end

  // One clock of stimulus on the SKEW=0 instance; the reference vector is updated alongside.
  task automatic applyStimulus(input logic we, input logic [31:0] wd, input logic st,
                               input logic cl, input logic rdy);
    bus0.wr_en = we; bus0.wr_dat = wd; bus0.start = st; bus0.clr = cl; bus0.out_ready = rdy;
    if (!cl && model_idle) begin
      if (we && model_vec.size() < DEPTH) model_vec.push_back(wd);
      if (st && model_vec.size() > 0) begin
        foreach (model_vec[i]) exp_q.push_back(model_vec[i]);
        model_idle = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (cl) begin
      exp_q.delete();
      model_vec.delete();
      model_idle = 1'b1;
    end
    bus0.wr_en = 1'b0; bus0.start = 1'b0; bus0.clr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!model_idle && k < 200) begin
      applyStimulus(1'b0, Z, 1'b0, 1'b0, 1'b1);
      k++;
    end
    checkOutput({name, "_finished"}, 32'(model_idle), 32'd1);
    checkOutput({name, "_done"}, 32'(bus0.done), 32'd1);
  endtask

  task automatic load_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, base + 32'(i), 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] held;

    bus0.wr_en = 0; bus0.wr_dat = 0; bus0.clr = 0; bus0.start = 0; bus0.out_ready = 0;
    bus2.wr_en = 0; bus2.wr_dat = 0; bus2.clr = 0; bus2.start = 0; bus2.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst0_valid", 32'(bus0.out_valid), 0);
    checkOutput("rst0_busy",  32'(bus0.busy), 0);
    checkOutput("rst0_done",  32'(bus0.done), 0);
    checkOutput("rst0_err",   32'(bus0.err_empty), 0);
    checkOutput("rst0_fill",  32'(bus0.fill_cnt), 0);
    checkOutput("rst0_wrr",   32'(bus0.wr_ready), 1);
    checkOutput("rst2_valid", 32'(bus2.out_valid), 0);
    checkOutput("rst2_busy",  32'(bus2.busy), 0);
    checkOutput("rst2_fill",  32'(bus2.fill_cnt), 0);

    // Cycle table: we wd st cl rdy | wr_ready fill valid dat busy done err
    tbl.push_back(row(0, Z,  1, 0, 1,  1, 0, 0, Z,  0, 0, 1));
    tbl.push_back(row(0, Z,  0, 0, 1,  1, 0, 0, Z,  0, 0, 0));
    tbl.push_back(row(1, W0, 0, 0, 1,  1, 1, 0, Z,  0, 0, 0));
    tbl.push_back(row(1, W1, 0, 0, 1,  1, 2, 0, Z,  0, 0, 0));
    tbl.push_back(row(1, W2, 0, 0, 1,  1, 3, 0, Z,  0, 0, 0));
    tbl.push_back(row(0, Z,  1, 0, 1,  0, 3, 1, W0, 1, 0, 0));
    tbl.push_back(row(0, Z,  0, 0, 1,  0, 3, 1, W1, 1, 0, 0));
    tbl.push_back(row(0, Z,  0, 0, 1,  0, 3, 1, W2, 1, 0, 0));
    tbl.push_back(row(0, Z,  0, 0, 1,  1, 3, 0, Z,  0, 1, 0));
    tbl.push_back(row(0, Z,  0, 0, 1,  1, 3, 0, Z,  0, 1, 0));
    for (int rep = 0; rep < 2; rep++) begin
      tbl.push_back(row(0, Z, 1, 0, 1,  0, 3, 1, W0, 1, 0, 0));
      tbl.push_back(row(0, Z, 0, 0, 1,  0, 3, 1, W1, 1, 0, 0));
      tbl.push_back(row(0, Z, 0, 0, 1,  0, 3, 1, W2, 1, 0, 0));
      tbl.push_back(row(0, Z, 0, 0, 1,  1, 3, 0, Z,  0, 1, 0));
    end
    tbl.push_back(row(1, W3, 0, 0, 1,  1, 4, 0, Z,  0, 0, 0));
    tbl.push_back(row(0, Z,  1, 0, 1,  0, 4, 1, W0, 1, 0, 0));
    tbl.push_back(row(0, Z,  0, 0, 1,  0, 4, 1, W1, 1, 0, 0));
    tbl.push_back(row(0, Z,  0, 0, 1,  0, 4, 1, W2, 1, 0, 0));
    tbl.push_back(row(0, Z,  0, 0, 1,  0, 4, 1, W3, 1, 0, 0));
    tbl.push_back(row(0, Z,  0, 0, 1,  1, 4, 0, Z,  0, 1, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].we, tbl[i].wd, tbl[i].st, tbl[i].cl, tbl[i].rdy);
      checkOutput($sformatf("row%0d_wrr", i),   32'(bus0.wr_ready),  32'(tbl[i].e_wrr));
      checkOutput($sformatf("row%0d_fill", i),  32'(bus0.fill_cnt),  32'(tbl[i].e_fill));
      checkOutput($sformatf("row%0d_valid", i), 32'(bus0.out_valid), 32'(tbl[i].e_vld));
      checkOutput($sformatf("row%0d_dat", i),   bus0.out_dat,        tbl[i].e_dat);
      checkOutput($sformatf("row%0d_busy", i),  32'(bus0.busy),      32'(tbl[i].e_busy));
      checkOutput($sformatf("row%0d_done", i),  32'(bus0.done),      32'(tbl[i].e_done));
      checkOutput($sformatf("row%0d_err", i),   32'(bus0.err_empty), 32'(tbl[i].e_err));
    end

    // Backpressure: five stalled cycles mid-stream must hold the presented word.
    applyStimulus(1'b0, Z, 1'b0, 1'b1, 1'b1);
    load_words(5, 32'h4100_0000);
    xfer_cnt = 0;
    applyStimulus(1'b0, Z, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, Z, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, Z, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, Z, 1'b0, 1'b0, 1'b0);
    held = bus0.out_dat;
    checkOutput("bp_held_word", held, 32'h4100_0002);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_valid%0d", i), 32'(bus0.out_valid), 1);
      checkOutput($sformatf("bp_dat%0d", i), bus0.out_dat, held);
      applyStimulus(1'b0, Z, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("bp_valid_last", 32'(bus0.out_valid), 1);
    checkOutput("bp_dat_last", bus0.out_dat, held);
    wait_idle("bp");
    checkOutput("bp_xfers", 32'(xfer_cnt), 5);

    // Full buffer: the 17th write is dropped and exactly DEPTH words stream out.
    applyStimulus(1'b0, Z, 1'b0, 1'b1, 1'b1);
    load_words(DEPTH, 32'h3F00_0000);
    checkOutput("full_wrr", 32'(bus0.wr_ready), 0);
    checkOutput("full_fill", 32'(bus0.fill_cnt), DEPTH);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    checkOutput("full_fill_after_drop", 32'(bus0.fill_cnt), DEPTH);
    xfer_cnt = 0;
    applyStimulus(1'b0, Z, 1'b1, 1'b0, 1'b1);
    wait_idle("full");
    checkOutput("full_xfers", 32'(xfer_cnt), DEPTH);

    // clr after two of four words, the second handshaking in the clr cycle itself.
    applyStimulus(1'b0, Z, 1'b0, 1'b1, 1'b1);
    load_words(4, 32'h4200_0000);
    xfer_cnt = 0;
    applyStimulus(1'b0, Z, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, Z, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, Z, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_valid", 32'(bus0.out_valid), 0);
    checkOutput("clr_fill", 32'(bus0.fill_cnt), 0);
    checkOutput("clr_done", 32'(bus0.done), 0);
    checkOutput("clr_busy", 32'(bus0.busy), 0);
    checkOutput("clr_xfers", 32'(xfer_cnt), 2);
    repeat (3) applyStimulus(1'b0, Z, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_valid_later", 32'(bus0.out_valid), 0);

    // start together with a write: the write is part of the streamed vector.
    applyStimulus(1'b1, W0, 1'b0, 1'b0, 1'b1);
    xfer_cnt = 0;
    applyStimulus(1'b1, W1, 1'b1, 1'b0, 1'b1);
    checkOutput("sw_valid", 32'(bus0.out_valid), 1);
    wait_idle("sw");
    checkOutput("sw_xfers", 32'(xfer_cnt), 2);
    checkOutput("sw_fill", 32'(bus0.fill_cnt), 2);

    // clr together with a write: the write is dropped.
    applyStimulus(1'b1, W2, 1'b0, 1'b1, 1'b1);
    checkOutput("cw_fill", 32'(bus0.fill_cnt), 0);

    // start while streaming is ignored.
    load_words(3, 32'h4300_0000);
    xfer_cnt = 0;
    applyStimulus(1'b0, Z, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, Z, 1'b1, 1'b0, 1'b0);
    checkOutput("rs_dat", bus0.out_dat, 32'h4300_0000);
    wait_idle("rs");
    checkOutput("rs_xfers", 32'(xfer_cnt), 3);

    // Reset in the middle of a stream.
    applyStimulus(1'b0, Z, 1'b0, 1'b1, 1'b1);
    load_words(2, 32'h4400_0000);
    applyStimulus(1'b0, Z, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_vec.delete();
    model_idle = 1'b1;
    checkOutput("mrst_valid", 32'(bus0.out_valid), 0);
    checkOutput("mrst_fill", 32'(bus0.fill_cnt), 0);
    checkOutput("mrst_busy", 32'(bus0.busy), 0);
    checkOutput("mrst_done", 32'(bus0.done), 0);

    // SKEW=2 instance: first valid three cycles after the start cycle.
    bus2.out_ready = 1'b1;
    bus2.wr_en = 1'b1; bus2.wr_dat = W0;
    @(posedge clk); #1;
    bus2.wr_dat = W1;
    @(posedge clk); #1;
    bus2.wr_en = 1'b0;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("skew_valid_t%0d", k), 32'(bus2.out_valid), 32'(k == 3 || k == 4));
      checkOutput($sformatf("skew_busy_t%0d", k),  32'(bus2.busy), 32'(k <= 4));
      checkOutput($sformatf("skew_done_t%0d", k),  32'(bus2.done), 32'(k == 5));
      if (k == 3) checkOutput("skew_dat0", bus2.out_dat, W0);
      if (k == 4) checkOutput("skew_dat1", bus2.out_dat, W1);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
